uart_rx_bit_timer: RTL and testbench

Parametrised bit-timing counter for the UART receiver, replacing the fixed 10-bit counter. It counts oversampled baud ticks within each bit and bits within each frame, with frame length selectable at run time. It produces a mid-bit sample strobe, per-bit end strobes and a frame-complete pulse for the RX controller FSM and shift register.

---
 rtl/uart_rx_bit_timer_if.sv | 29 ++
 rtl/uart_rx_bit_timer.sv | 121 ++++++++++++
 tb/tb_uart_rx_bit_timer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_bit_timer_if.sv
// Control/status bundle between the RX controller and the bit timer.
interface uart_rx_bit_timer_if #(
  parameter int unsigned MAX_BITS = 12
);
  localparam int unsigned IDX_W = $clog2(MAX_BITS + 1);

  logic             clear;
  logic             start;
  logic             tick;
  logic [IDX_W-1:0] frame_bits;
  logic             busy;
  logic             sample;
  logic [IDX_W-1:0] bit_idx;
  logic             bit_end;
  logic             frame_done;
  logic             cfg_err;

  // Controller side: issues commands and ticks, observes strobes.
  modport master (
    output clear, start, tick, frame_bits,
    input  busy, sample, bit_idx, bit_end, frame_done, cfg_err
  );

  // Timer side.
  modport slave (
    input  clear, start, tick, frame_bits,
    output busy, sample, bit_idx, bit_end, frame_done, cfg_err
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Oversampled bit/frame timer for the UART receiver: mid-bit sample strobe,
// per-bit end strobes and a frame-complete pulse, run-time frame length.
module uart_rx_bit_timer #(
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned MAX_BITS     = 12,
  parameter int unsigned SAMPLE_POINT = OVERSAMPLE / 2
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_bit_timer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MAX_BITS + 1);
  localparam int unsigned SUB_W = $clog2(OVERSAMPLE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;
  logic             sample_q, sample_d;
  logic             bit_end_q, bit_end_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic len_ok;
  logic accept;
  logic last_tick;
  logic last_bit;

  assign len_ok    = (bus.frame_bits != '0) && (bus.frame_bits <= IDX_W'(MAX_BITS));
  assign accept    = (state_q == IDLE) && bus.start && len_ok;
  assign last_tick = (sub_cnt_q == SUB_W'(OVERSAMPLE - 1));
  assign last_bit  = (bit_idx_q == IDX_W'(len_q - IDX_W'(1)));

  // State and registered-output storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sub_cnt_q    <= '0;
      len_q        <= '0;
      bit_idx_q    <= '0;
      busy_q       <= 1'b0;
      sample_q     <= 1'b0;
      bit_end_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_cnt_q    <= sub_cnt_d;
      len_q        <= len_d;
      bit_idx_q    <= bit_idx_d;
      busy_q       <= busy_d;
      sample_q     <= sample_d;
      bit_end_q    <= bit_end_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Next-state: clear aborts; frame ends on the last tick of the last bit.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = RUN;
        RUN:  if (bus.tick && last_tick && last_bit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters and next values of the registered outputs.
  always_comb begin
    sub_cnt_d    = sub_cnt_q;
    len_d        = len_q;
    bit_idx_d    = bit_idx_q;
    sample_d     = 1'b0;
    bit_end_d    = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    busy_d       = (state_d == RUN);
    if (bus.clear) begin
      sub_cnt_d = '0;
      len_d     = '0;
      bit_idx_d = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        len_d     = bus.frame_bits;
        sub_cnt_d = '0;
        bit_idx_d = '0;
      end else if (bus.start) begin
        cfg_err_d = 1'b1;
      end
    end else if (bus.tick) begin
      sample_d = (sub_cnt_q == SUB_W'(SAMPLE_POINT - 1));
      if (last_tick) begin
        sub_cnt_d = '0;
        bit_end_d = 1'b1;
        if (last_bit) begin
          frame_done_d = 1'b1;
          bit_idx_d    = '0;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end else begin
        sub_cnt_d = sub_cnt_q + SUB_W'(1);
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.sample     = sample_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.bit_end    = bit_end_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed self-checking bench for uart_rx_bit_timer at default parameters.
module tb_uart_rx_bit_timer;
  localparam int OS = 16;
  localparam int SP = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   k;
  int   nfd;
  logic fired;

  uart_rx_bit_timer_if #(.MAX_BITS(12)) bus ();

  uart_rx_bit_timer #(.OVERSAMPLE(16), .MAX_BITS(12), .SAMPLE_POINT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Packed view {busy, sample, bit_end, frame_done, cfg_err, bit_idx}.
  function automatic logic [8:0] obs();
    return {bus.busy, bus.sample, bus.bit_end, bus.frame_done, bus.cfg_err, bus.bit_idx};
  endfunction

  function automatic logic [8:0] mk(logic b, logic s, logic e, logic f, logic c, logic [3:0] i);
    return {b, s, e, f, c, i};
  endfunction

  // Expected outputs after the t-th counted tick of an n-bit frame; strobes only if a tick fired.
  function automatic logic [8:0] exp_run(int t, int n, logic fire);
    int tot;
    logic [3:0] idx;
    tot = n * OS;
    idx = (t >= tot) ? 4'd0 : 4'(t / OS);
    return mk(t < tot, fire && t > 0 && (t % OS) == SP, fire && t > 0 && (t % OS) == 0,
              fire && t == tot, 1'b0, idx);
  endfunction

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (busy,smp,bend,fdone,cerr,idx)", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame10(input string tag);
    bus.frame_bits = 4'd10;
    bus.start      = 1'b1;
    bus.tick       = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk({tag, "_accept"}, obs(), exp_run(0, 10, 1'b1));
    for (int t = 1; t <= 10 * OS; t++) begin
      cyc();
      chk(tag, obs(), exp_run(t, 10, 1'b1));
    end
    bus.tick = 1'b0;
    cyc();
    chk({tag, "_after"}, obs(), 9'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;
    bus.tick       = 1'b0;
    bus.frame_bits = '0;
    cyc();
    chk("reset", obs(), 9'd0);
    rst = 1'b0;
    cyc();
    chk("post_reset", obs(), 9'd0);

    // Full 10-bit frame, tick every cycle.
    frame10("frame10");

    // Illegal lengths raise cfg_err once and never start.
    bus.tick       = 1'b1;
    bus.frame_bits = 4'd0;
    bus.start      = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("cfg_err_len0", obs(), mk(0, 0, 0, 0, 1, 0));
    cyc();
    chk("cfg_err_len0_end", obs(), 9'd0);
    bus.frame_bits = 4'd13;
    bus.start      = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("cfg_err_len13", obs(), mk(0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("cfg_err_idle", obs(), 9'd0);
    end

    // Abort at tick 50 with clear and start together.
    bus.frame_bits = 4'd10;
    bus.start      = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("abort_accept", obs(), exp_run(0, 10, 1'b1));
    for (int t = 1; t < 50; t++) begin
      cyc();
      chk("abort_run", obs(), exp_run(t, 10, 1'b1));
    end
    bus.clear = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk("abort_clear", obs(), 9'd0);
    cyc();
    chk("abort_idle", obs(), 9'd0);
    bus.tick = 1'b0;
    frame10("after_clear");

    // Start held, 2-bit frames back to back: 33-cycle period.
    bus.frame_bits = 4'd2;
    bus.start      = 1'b1;
    bus.tick       = 1'b1;
    nfd = 0;
    cyc();
    chk("b2b_accept", obs(), exp_run(0, 2, 1'b1));
    for (int c = 1; c < 100; c++) begin
      cyc();
      if (bus.frame_done === 1'b1) nfd++;
      chk("b2b", obs(), exp_run(c % 33, 2, 1'b1));
    end
    total++;
    assert (nfd == 3) else begin
      bad++;
      $error("FAIL b2b_count observed=%0d expected=3", nfd);
    end
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("b2b_clear", obs(), 9'd0);

    // 1-bit frame, tick every 3rd cycle; pre-start ticks and mid-frame length change ignored.
    bus.frame_bits = 4'd1;
    bus.tick       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pre_tick", obs(), 9'd0);
    end
    bus.tick  = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("slow_accept", obs(), mk(1, 0, 0, 0, 0, 0));
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      fired    = ((i % 3) == 0);
      bus.tick = fired;
      cyc();
      if (fired) k++;
      chk("slow", obs(), (k > 16) ? 9'd0 : exp_run(k, 1, fired));
      if (k == 4) bus.frame_bits = 4'd5;
    end
    bus.tick = 1'b0;

    // Asynchronous reset between clock edges mid-frame.
    bus.frame_bits = 4'd10;
    bus.start      = 1'b1;
    bus.tick       = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      cyc();
      chk("pre_rst", obs(), exp_run(t, 10, 1'b1));
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", obs(), 9'd0);
    cyc();
    chk("rst_held", obs(), 9'd0);
    rst      = 1'b0;
    bus.tick = 1'b0;
    cyc();
    chk("rst_released", obs(), 9'd0);
    frame10("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
